ssd_pager: RTL and testbench



---
 rtl/ssd_pager_pkg.sv | 20 ++
 rtl/ssd_pager_if.sv | 19 +
 rtl/ssd_hex_digit.sv | 14 +
 rtl/ssd_pager.sv | 132 +++++++++++++
 tb/tb_ssd_pager.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ssd_pager_pkg.sv
// Shared types and hex-to-segment table for the paged seven-segment driver.
package ssd_pkg;

  typedef logic [7:0] seg_t;

  localparam seg_t SEG_BLANK = 8'h00;

  // Bit order {dp,g,f,e,d,c,b,a}, active-high.
  localparam seg_t HEX_SEG [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  function automatic seg_t hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

  typedef enum logic {SSD_EMPTY, SSD_SHOW} ssd_state_e;

endpackage

// File: rtl/ssd_pager_if.sv
// Display bus between the core (master) and the pager (slave).
interface ssd_pager_if #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned NIB    = DATA_W / 4;
  localparam int unsigned PAGES  = (NIB + DIGITS - 1) / DIGITS;
  localparam int unsigned PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;

  logic                  load;
  logic [DATA_W-1:0]     value;
  logic                  freeze;
  logic [8*DIGITS-1:0]   ss;
  logic [PAGE_W-1:0]     page;
  logic                  shown_valid;

  modport master (output load, value, freeze, input ss, page, shown_valid);
  modport slave  (input load, value, freeze, output ss, page, shown_valid);
endinterface

// File: rtl/ssd_hex_digit.sv
// One seven-segment digit: hex decode with blanking and a separate decimal point.
module ssd_hex_digit
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  input  logic       dp,
  output seg_t       seg
);
  always_comb begin
    seg    = blank ? SEG_BLANK : hex_to_seg(nibble);
    seg[7] = dp;
  end
endmodule

// File: rtl/ssd_pager.sv
// Latches a value and pages its nibbles across DIGITS seven-segment digits.
// Define SSD_PAGER_LZB_EN for leading-zero blanking and skipping of all-blank pages.
module ssd_pager
  import ssd_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned HOLD_TICKS = 200
) (
  input logic       clk,
  input logic       reset,
  ssd_pager_if.slave bus
);
  localparam int unsigned NIB    = DATA_W / 4;
  localparam int unsigned PAGES  = (NIB + DIGITS - 1) / DIGITS;
  localparam int unsigned PAGE_W = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam int unsigned TICK_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
  localparam int unsigned EXT_W  = 4 * PAGES * DIGITS;

  ssd_state_e          state_q, state_d;
  logic [DATA_W-1:0]   value_q, value_d;
  logic [PAGE_W-1:0]   page_q, page_d;
  logic [TICK_W-1:0]   tick_q, tick_d;
  logic [8*DIGITS-1:0] ss_q, ss_d;
  logic [PAGE_W-1:0]   last;

`ifdef SSD_PAGER_LZB_EN
  localparam int unsigned MSN_W = (NIB > 1) ? $clog2(NIB) : 1;
  logic [MSN_W-1:0]  msn;
  logic [PAGE_W-1:0] last_q;
  logic              last_ok_q;

  always_comb begin
    msn = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (4'(value_q >> (4 * i)) != 4'd0) msn = MSN_W'(i);
    end
  end

  // last_q trails value_q by a cycle; hold at page 0 until it has caught up.
  always_ff @(posedge clk) begin
    if (reset || bus.load) begin
      last_q    <= '0;
      last_ok_q <= 1'b0;
    end else begin
      last_q    <= PAGE_W'(32'(msn) / DIGITS);
      last_ok_q <= 1'b1;
    end
  end

  assign last = last_ok_q ? last_q : '0;
`else
  assign last = PAGE_W'(PAGES - 1);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= SSD_EMPTY;
      value_q <= '0;
      page_q  <= '0;
      tick_q  <= '0;
      ss_q    <= '0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      page_q  <= page_d;
      tick_q  <= tick_d;
      ss_q    <= ss_d;
    end
  end

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    page_d  = page_q;
    tick_d  = tick_q;
    if (bus.load) begin
      state_d = SSD_SHOW;
      value_d = bus.value;
      page_d  = '0;
      tick_d  = '0;
    end else if (state_q == SSD_SHOW && !bus.freeze) begin
      if (tick_q == TICK_W'(HOLD_TICKS - 1)) begin
        tick_d = '0;
        page_d = (page_q >= last) ? '0 : page_q + 1'b1;
      end else begin
        tick_d = tick_q + 1'b1;
      end
    end
  end

  logic [EXT_W-1:0] val_ext;
  seg_t             seg [DIGITS];

  assign val_ext = EXT_W'(value_q);

  for (genvar d = 0; d < DIGITS; d++) begin : g_digit
    logic [31:0] idx;
    logic [3:0]  nib;
    logic        blank;
    logic        dp;

    assign idx = 32'(page_q) * DIGITS + d;
    assign nib = 4'(val_ext >> (4 * idx));
`ifdef SSD_PAGER_LZB_EN
    assign blank = (idx >= NIB) || (idx > 32'(msn));
`else
    assign blank = (idx >= NIB);
`endif
    // Digit 0 dp flags that an upper page is on display.
    assign dp = (d == 0) && (page_q != '0);

    ssd_hex_digit u_digit (
      .nibble (nib),
      .blank  (blank),
      .dp     (dp),
      .seg    (seg[d])
    );
  end

  always_comb begin
    ss_d = '0;
    if (state_q == SSD_SHOW) begin
      for (int unsigned d = 0; d < DIGITS; d++) ss_d[8*d +: 8] = seg[d];
    end
  end

  assign bus.ss          = ss_q;
  assign bus.page        = page_q;
  assign bus.shown_valid = (state_q == SSD_SHOW);

endmodule

// File: tb/tb_ssd_pager.sv
// Bench for ssd_pager (4 digits, 32-bit value, 3-tick hold) against a page/tick model.
module tb_ssd_pager;
  localparam int DIGITS = 4;
  localparam int DATA_W = 32;
  localparam int HOLD   = 3;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Reference state: what the display is showing, as the user sees it.
  bit          m_valid;
  logic [31:0] m_value;
  int          m_page, m_tick;
  logic [31:0] m_ss;

  ssd_pager_if #(.DIGITS(DIGITS), .DATA_W(DATA_W)) bus ();

  ssd_pager #(.DIGITS(DIGITS), .DATA_W(DATA_W), .HOLD_TICKS(HOLD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic int top_nibble(input logic [31:0] v);
    int m = 0;
    for (int i = 0; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) m = i;
    return m;
  endfunction

  function automatic int last_page(input logic [31:0] v);
`ifdef SSD_PAGER_LZB_EN
    return top_nibble(v) / DIGITS;
`else
    return (8 + DIGITS - 1) / DIGITS - 1;
`endif
  endfunction

  function automatic logic [31:0] render(input logic [31:0] v, input int p);
    logic [31:0] r = '0;
    for (int d = 0; d < DIGITS; d++) begin
      int idx = p * DIGITS + d;
      logic [7:0] s;
      bit blank = (idx >= 8);
`ifdef SSD_PAGER_LZB_EN
      if (idx > top_nibble(v)) blank = 1;
`endif
      s = blank ? 8'h00 : hex_tab[(v >> (4 * idx)) & 32'hF];
      if (d == 0 && p != 0) s = s | 8'h80;
      r[8*d +: 8] = s;
    end
    return r;
  endfunction

  task automatic step(input bit rst_v, input bit ld, input logic [31:0] v, input bit frz);
    logic [31:0] nss;
    reset = rst_v; bus.load = ld; bus.value = v; bus.freeze = frz;
    @(posedge clk);
    nss = m_valid ? render(m_value, m_page) : 32'h0;
    if (rst_v) begin
      m_valid = 0; m_value = 0; m_page = 0; m_tick = 0; m_ss = 0;
    end else begin
      m_ss = nss;
      if (ld) begin
        m_valid = 1; m_value = v; m_page = 0; m_tick = 0;
      end else if (m_valid && !frz) begin
        if (m_tick == HOLD - 1) begin
          m_tick = 0;
          m_page = (m_page >= last_page(m_value)) ? 0 : m_page + 1;
        end else begin
          m_tick++;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    vectors++;
    if (bus.ss !== 32'h0 || bus.page !== 1'b0 || bus.shown_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset: ss=%h page=%0d valid=%b, need 0/0/0", bus.ss, bus.page,
               bus.shown_valid);
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 32'(i) * 32'h1111, 0);
      vectors++;
      if (bus.ss !== 32'h0 || bus.shown_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_no_load: ss=%h valid=%b, need 0/0", bus.ss, bus.shown_valid);
      end
    end
  endtask

  task automatic test_paging();
    logic [31:0] exp_ss [8] = '{32'h0, 32'h666D7D07, 32'h666D7D07, 32'h666D7D07,
                                32'h3F065BCF, 32'h3F065BCF, 32'h3F065BCF, 32'h666D7D07};
    int          exp_pg [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    step(0, 1, 32'h01234567, 0);
    vectors++;
    if (bus.page !== 1'b0 || bus.shown_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL load_page_valid: page=%0d valid=%b, need 0/1", bus.page, bus.shown_valid);
    end
    for (int i = 1; i < 8; i++) begin
      step(0, 0, 0, 0);
      vectors++;
      if (bus.ss !== exp_ss[i] || bus.page !== 1'(exp_pg[i])) begin
        miscompares++;
        $display("FAIL paging[%0d]: ss=%h page=%0d, need %h/%0d", i, bus.ss, bus.page,
                 exp_ss[i], exp_pg[i]);
      end
    end
  endtask

  task automatic goto_page1(input string tag);
    int n = 0;
    while (m_page != 1 && n < 10) begin
      step(0, 0, 0, 0);
      n++;
    end
    vectors++;
    if (bus.page !== 1'b1) begin
      miscompares++;
      $display("FAIL %s_reach_page1: page=%0d, need 1", tag, bus.page);
    end
  endtask

  task automatic test_freeze();
    goto_page1("freeze");
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 32'hFFFF_FFFF, 1);
      vectors++;
      if (bus.page !== 1'b1 || bus.ss !== 32'h3F065BCF) begin
        miscompares++;
        $display("FAIL freeze[%0d]: ss=%h page=%0d, need 3f065bcf/1", i, bus.ss, bus.page);
      end
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0);
      vectors++;
      if (bus.page !== ((i < 3) ? 1'b1 : 1'b0)) begin
        miscompares++;
        $display("FAIL unfreeze[%0d]: page=%0d, need %0d", i, bus.page, (i < 3) ? 1 : 0);
      end
    end
  endtask

  task automatic test_reload();
    goto_page1("reload");
    step(0, 0, 0, 0);
    step(0, 1, 32'h89ABCDEF, 0);
    vectors++;
    if (bus.page !== 1'b0) begin
      miscompares++;
      $display("FAIL reload_page: page=%0d, need 0", bus.page);
    end
    for (int i = 1; i <= 3; i++) begin
      step(0, 0, 0, 0);
      vectors++;
      if (bus.page !== ((i < 3) ? 1'b0 : 1'b1) || (i < 3 && bus.ss !== 32'h395E7971)) begin
        miscompares++;
        $display("FAIL reload_hold[%0d]: ss=%h page=%0d, need 395e7971/%0d", i, bus.ss,
                 bus.page, (i < 3) ? 0 : 1);
      end
    end
  endtask

`ifdef SSD_PAGER_LZB_EN
  task automatic test_lzb();
    step(0, 1, 32'h000000A0, 0);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0);
      vectors++;
      if (bus.page !== 1'b0 || bus.ss !== 32'h0000773F) begin
        miscompares++;
        $display("FAIL lzb_a0[%0d]: ss=%h page=%0d, need 0000773f/0", i, bus.ss, bus.page);
      end
    end
    step(0, 1, 32'h0, 0);
    step(0, 0, 0, 0);
    vectors++;
    if (bus.ss !== 32'h0000003F) begin
      miscompares++;
      $display("FAIL lzb_zero: ss=%h, need 0000003f", bus.ss);
    end
  endtask
`endif

  task automatic test_reset_over_load();
    step(0, 1, 32'h01234567, 0);
    goto_page1("rst_load");
    step(1, 1, 32'h55555555, 0);
    vectors++;
    if (bus.ss !== 32'h0 || bus.page !== 1'b0 || bus.shown_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_over_load: ss=%h page=%0d valid=%b, need 0/0/0", bus.ss,
               bus.page, bus.shown_valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] v = $urandom;
      if ($urandom_range(0, 1) == 0) v = v >> (4 * $urandom_range(0, 7));
      step($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0, v,
           $urandom_range(0, 3) == 0);
      vectors++;
      if (bus.ss !== m_ss || bus.page !== 1'(m_page) || bus.shown_valid !== m_valid) begin
        miscompares++;
        $display("FAIL random[%0d]: ss=%h page=%0d valid=%b, need %h/%0d/%b", i, bus.ss,
                 bus.page, bus.shown_valid, m_ss, m_page, m_valid);
      end
    end
  endtask

  initial begin
    reset = 1'b1; bus.load = 1'b0; bus.value = '0; bus.freeze = 1'b0;
    m_valid = 0; m_value = 0; m_page = 0; m_tick = 0; m_ss = 0;
    test_reset();
    test_paging();
    test_freeze();
    test_reload();
`ifdef SSD_PAGER_LZB_EN
    test_lzb();
`endif
    test_reset_over_load();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
